// File: rtl/det_arb_pkg.sv
// Shared definitions for the determinant arbiter and its pipelined datapath.
// Holds default sizes, the result width and the ID-to-one-hot helper.
package det_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 12;
    localparam int RW       = 2 * W_DEF;

    typedef struct packed {
        logic signed [W_DEF-1:0] a;
        logic signed [W_DEF-1:0] b;
        logic signed [W_DEF-1:0] c;
        logic signed [W_DEF-1:0] d;
    } det_op_t;

    // Covers up to 8 requesters; callers size-cast the result down to NREQ.
    function automatic logic [7:0] id2onehot(input logic [2:0] id);
        return 8'(1) << id;
    endfunction

endpackage

// File: rtl/det_pipe.sv
// Two-stage pipelined determinant a*d - b*c with valid and ID passthrough.
// Stage 1 registers both products, stage 2 registers the difference and one-hot strobe.
module det_pipe
    import det_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [IDW-1:0]        op_id,
    input  logic signed [W-1:0]   op_a,
    input  logic signed [W-1:0]   op_b,
    input  logic signed [W-1:0]   op_c,
    input  logic signed [W-1:0]   op_d,
    output logic [NREQ-1:0]       res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [2*W-1:0]        res_data,
    output logic                  busy
);

    localparam int PW = 2 * W;

    logic                  s1_valid;
    logic [IDW-1:0]        s1_id;
    logic signed [PW-1:0]  p0;
    logic signed [PW-1:0]  p1;
    logic signed [PW-1:0]  a_x, b_x, c_x, d_x;

    assign a_x = $signed({{W{op_a[W-1]}}, op_a});
    assign b_x = $signed({{W{op_b[W-1]}}, op_b});
    assign c_x = $signed({{W{op_c[W-1]}}, op_c});
    assign d_x = $signed({{W{op_d[W-1]}}, op_d});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            p0       <= '0;
            p1       <= '0;
        end else begin
            s1_valid <= op_valid;
            if (op_valid) begin
                s1_id <= op_id;
                p0    <= a_x * d_x;
                p1    <= b_x * c_x;
            end
        end
    end

    // Data and ID hold between results; only res_valid qualifies them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= '0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= s1_valid ? NREQ'(id2onehot(3'(s1_id))) : '0;
            if (s1_valid) begin
                res_id   <= s1_id;
                res_data <= p0 - p1;
            end
        end
    end

    assign busy = s1_valid | (|res_valid);

endmodule

// File: rtl/det_arbiter.sv
// Round-robin arbiter with per-requester burst lock in front of one shared
// determinant pipeline; results return one-hot tagged to the winning requester.
module det_arbiter
    import det_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ*W-1:0]     req_a,
    input  logic [NREQ*W-1:0]     req_b,
    input  logic [NREQ*W-1:0]     req_c,
    input  logic [NREQ*W-1:0]     req_d,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*W-1:0]        rsp_data,
    output logic                  busy
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic           grant_ok;
    logic           handshake;
    logic [W-1:0]   a_arr [NREQ];
    logic [W-1:0]   b_arr [NREQ];
    logic [W-1:0]   c_arr [NREQ];
    logic [W-1:0]   d_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*W +: W];
            b_arr[i] = req_b[i*W +: W];
            c_arr[i] = req_c[i*W +: W];
            d_arr[i] = req_d[i*W +: W];
        end
    end

    // Rotating-priority search: first valid requester at or after ptr wins.
    always_comb begin
        grant_ok = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_ok && req_valid[cand]) begin
                grant_ok = 1'b1;
                grant_id = cand;
            end
        end
    end

    assign handshake = grant_ok & ~reset;

    always_comb begin
        req_ready = '0;
        if (handshake)
            req_ready = NREQ'(id2onehot(3'(grant_id)));
    end

    // A locked winner keeps priority by leaving ptr on itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (handshake) begin
            if (req_lock[grant_id])
                ptr <= grant_id;
            else if (grant_id == IDW'(NREQ - 1))
                ptr <= '0;
            else
                ptr <= grant_id + IDW'(1);
        end
    end

    det_pipe #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (handshake),
        .op_id     (grant_id),
        .op_a      ($signed(a_arr[grant_id])),
        .op_b      ($signed(b_arr[grant_id])),
        .op_c      ($signed(c_arr[grant_id])),
        .op_d      ($signed(d_arr[grant_id])),
        .res_valid (rsp_valid),
        .res_id    (rsp_id),
        .res_data  (rsp_data),
        .busy      (busy)
    );

endmodule

// File: doc/det_arbiter.md
# det_arbiter

Shared-resource controller for the 2×2 determinant datapath (o = a·d − b·c) used by the geofence engine. It time-multiplexes one pipelined determinant unit among NREQ requesters: ordering, polygon-area and reference-point stages, plus any future geometry blocks. Arbitration is round-robin, with an optional per-requester burst lock for multi-step sequences. Results return tagged with the requester ID. The block sits between the geometry FSMs and a single multiplier pair, replacing per-block copies of the determinant unit.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 12, signed operand width; result width is 2W
- IDW, $clog2(NREQ), requester ID width
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high; clock clk
- req_valid  in  NREQ  per-requester operation request
- req_lock  in  NREQ  requester holds the grant after its current handshake
- req_a, req_b, req_c, req_d  in  NREQ*W each  signed operands, requester i in bits [i*W +: W]
- req_ready  out  NREQ  one-hot grant; the handshake occurs when valid&ready
- rsp_valid  out  NREQ  one-hot result strobe to the owning requester
- rsp_id  out  IDW  ID of the result's requester
- rsp_data  out  2W  signed a·d − b·c
- busy  out  1  any pipeline stage occupied

## Operation
- Arbitration (combinational, same cycle):
  - Search starts at ptr and wraps modulo NREQ.
  - The first i with req_valid[i] gets req_ready[i]=1. All other ready bits are 0.
  - If no requester is valid, req_ready=0.
- Pointer update on handshake by requester g:
  - If req_lock[g]=1, ptr←g.
  - Otherwise ptr←(g+1) mod NREQ.
  - Without a handshake, ptr holds.
- Lock semantics:
  - The locked owner wins every cycle it stays valid.
  - If it drops valid, the search moves on from g and another requester may win.
  - There is no starvation timer. Requesters must bound their lock bursts; geofence holds at most 13 consecutive ops.
- Datapath: 2-stage pipeline.
  - S1 registers sign-extended products p0=a·d and p1=b·c (2W bits each) plus valid and ID.
  - S2 registers rsp_data=p0−p1, rsp_valid=onehot(id) and rsp_id.
- Arithmetic:
  - Full-precision signed arithmetic; no truncation or saturation.
  - 2W bits suffice for all W-bit signed inputs.
- Responses are fire-and-forget. There is no rsp backpressure; requesters must capture the result on rsp_valid.
- Operands must be stable only during the handshake cycle.
- FSM per requester is not required; the pipeline valid bits are the only control state besides ptr.

## Timing
- Throughput: one operation per cycle across all requesters.
- Latency: handshake at cycle T → rsp_valid and rsp_data at cycle T+2, fixed.
- Back-to-back handshakes from one requester return in order, one per cycle.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Reset values:
  - ptr=0, S1/S2 valid=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0.
- Reset mid-operation: in-flight results are discarded. No rsp_valid pulses are emitted after reset deasserts until new handshakes complete.
- When S2 is not valid, rsp_data holds its last value; only rsp_valid qualifies it.
- busy=1 whenever S1 or S2 is valid. It falls to 0 two cycles after the last handshake.

## Structure
- Shared package det_arb_pkg holds:
  - Default NREQ/W.
  - Function id2onehot.
  - The result width constant RW=2*W.
  - Typedef det_op_t {a,b,c,d}.
- Sub-module det_pipe: 2-stage pipelined a·d−b·c with valid/ID passthrough, so other blocks can reuse it.
- The arbiter (ptr register and rotate-priority search) stays in det_arbiter.

## Test plan
- Single op: req0 a=3,b=2,c=1,d=4 at cycle T → rsp_valid=4'b0001, rsp_id=0, rsp_data=10 at T+2.
- Extremes: a=−2048, b=2047, c=−2048, d=−2048 → rsp_data=8386560. Also a=d=0, b=c=−2048 → −4194304.
- Round robin: all four valid continuously from reset → grants 0,1,2,3,0,1. Responses arrive in the same order, each 2 cycles after its grant.
- Lock: req1 with lock=1 valid for 5 cycles while req2 is valid → req1 granted 5 times consecutively. req2 is granted in the cycle req1 drops valid.
- Idle gap: req3 single op, then 3 idle cycles → busy=1 for exactly 2 cycles, then busy=0. ptr=0, so the next lone req0 is granted immediately.
- Reset mid-flight: assert reset one cycle after a handshake → rsp_valid never pulses for that op, all outputs read 0, and the next op after release behaves as in the single-op case.
